// File: rtl/glb_tile_intr_ctrl.sv
// Tile interrupt controller: collects glb_core done pulses into W1C pending/overrun bits,
// gates them through MASK/CTRL into a registered interrupt. Optional counters: GLB_INTR_COUNT_EN.
module glb_tile_intr_ctrl #(
  parameter int CFG_ADDR_WIDTH = 4,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      strm_f2g_interrupt_pulse,
  input  logic                      strm_g2f_interrupt_pulse,
  input  logic                      pcfg_g2f_interrupt_pulse,
  input  logic                      cfg_wr_en,
  input  logic                      cfg_rd_en,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data,
  output logic [CFG_DATA_WIDTH-1:0] cfg_rd_data,
  output logic                      cfg_rd_data_valid,
  output logic                      interrupt
);
  localparam logic [CFG_ADDR_WIDTH-1:0] A_STATUS = CFG_ADDR_WIDTH'(0);
  localparam logic [CFG_ADDR_WIDTH-1:0] A_MASK   = CFG_ADDR_WIDTH'(1);
  localparam logic [CFG_ADDR_WIDTH-1:0] A_CTRL   = CFG_ADDR_WIDTH'(2);

  logic [2:0] src;
  logic [2:0] pending_q, pending_d, overrun_q, overrun_d, mask_q, mask_d;
  logic [2:0] clr_pend, clr_ovr;
  logic       ctrl_q, ctrl_d, interrupt_q, interrupt_d, rd_valid_q, rd_valid_d;
  logic       wr_status;
  logic [CFG_DATA_WIDTH-1:0] rd_data_q, rd_data_d, rd_mux;
  logic       unused_wr_data;

  assign src = {pcfg_g2f_interrupt_pulse, strm_g2f_interrupt_pulse, strm_f2g_interrupt_pulse};
  assign unused_wr_data = ^cfg_wr_data;

  always_comb begin
    wr_status = cfg_wr_en && (cfg_addr == A_STATUS);
    clr_pend  = wr_status ? cfg_wr_data[2:0] : 3'b000;
    clr_ovr   = wr_status ? cfg_wr_data[5:3] : 3'b000;
    // A pulse beats a same-cycle clear; a pulse landing on a bit being cleared is not an overrun.
    pending_d = (pending_q & ~clr_pend) | src;
    overrun_d = (overrun_q & ~clr_ovr) | (src & pending_q & ~clr_pend);
    mask_d    = (cfg_wr_en && cfg_addr == A_MASK) ? cfg_wr_data[2:0] : mask_q;
    ctrl_d    = (cfg_wr_en && cfg_addr == A_CTRL) ? cfg_wr_data[0] : ctrl_q;
    interrupt_d = ctrl_q & (|(pending_q & mask_q));
  end

`ifdef GLB_INTR_COUNT_EN
  localparam logic [CFG_ADDR_WIDTH-1:0] A_CNT0 = CFG_ADDR_WIDTH'(3);
  localparam logic [CFG_ADDR_WIDTH-1:0] A_CNT1 = CFG_ADDR_WIDTH'(4);
  localparam logic [CFG_ADDR_WIDTH-1:0] A_CNT2 = CFG_ADDR_WIDTH'(5);

  logic [2:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 3; k++) begin
      if (cfg_wr_en && cfg_addr == CFG_ADDR_WIDTH'(3 + k))
        cnt_d[k] = CNT_WIDTH'(src[k]);
      else if (src[k] && cnt_q[k] != {CNT_WIDTH{1'b1}})
        cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)      cnt_q <= '0;
    else if (clk_en) cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      A_STATUS: rd_mux[5:0] = {overrun_q, pending_q};
      A_MASK:   rd_mux[2:0] = mask_q;
      A_CTRL:   rd_mux[0]   = ctrl_q;
`ifdef GLB_INTR_COUNT_EN
      A_CNT0:   rd_mux[CNT_WIDTH-1:0] = cnt_q[0];
      A_CNT1:   rd_mux[CNT_WIDTH-1:0] = cnt_q[1];
      A_CNT2:   rd_mux[CNT_WIDTH-1:0] = cnt_q[2];
`endif
      default:  rd_mux = '0;
    endcase
    rd_valid_d = cfg_rd_en;
    rd_data_d  = cfg_rd_en ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      mask_q      <= '0;
      ctrl_q      <= 1'b0;
      interrupt_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else if (clk_en) begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      mask_q      <= mask_d;
      ctrl_q      <= ctrl_d;
      interrupt_q <= interrupt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign cfg_rd_data       = rd_data_q;
  assign cfg_rd_data_valid = rd_valid_q;
  assign interrupt         = interrupt_q;
endmodule

// File: tb/tb_glb_tile_intr_ctrl.sv
// Directed + random bench for glb_tile_intr_ctrl against a cycle-level behavioural model.
module tb_glb_tile_intr_ctrl;
  localparam int AW = 4, DW = 32, CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clk_en, f2g, g2f, pcfg, wr_en, rd_en, interrupt, rd_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;

  glb_tile_intr_ctrl #(.CFG_ADDR_WIDTH(AW), .CFG_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .strm_f2g_interrupt_pulse(f2g), .strm_g2f_interrupt_pulse(g2f),
    .pcfg_g2f_interrupt_pulse(pcfg),
    .cfg_wr_en(wr_en), .cfg_rd_en(rd_en), .cfg_addr(addr), .cfg_wr_data(wr_data),
    .cfg_rd_data(rd_data), .cfg_rd_data_valid(rd_valid), .interrupt(interrupt)
  );

  int n_chk = 0, n_fail = 0;
  int m_pend[3], m_ovr[3], m_cnt[3];
  int m_mask, m_ctrl, m_irq, m_rv;
  logic [31:0] m_rd;
`ifdef GLB_INTR_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = 0;
    if (a == 0) begin
      for (int k = 0; k < 3; k++) v = v + (m_pend[k] << k) + (m_ovr[k] << (k + 3));
    end else if (a == 1) v = m_mask;
    else if (a == 2) v = m_ctrl;
    else if (a >= 3 && a <= 5 && CNT_ON) v = m_cnt[a - 3];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare all outputs.
  task automatic cyc(input logic [2:0] p, input logic wr = 0, input logic rd = 0,
                     input int a = 0, input logic [31:0] wd = 0,
                     input logic en = 1, input logic rst_n = 1);
    int irq_n, np[3], no[3];
    bit w1c;
    {pcfg, g2f, f2g} = p;
    wr_en = wr; rd_en = rd; addr = AW'(a); wr_data = wd; clk_en = en; reset = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin m_pend[k] = 0; m_ovr[k] = 0; m_cnt[k] = 0; end
      m_mask = 0; m_ctrl = 0; m_irq = 0; m_rv = 0; m_rd = 0;
    end else if (en) begin
      irq_n = 0;
      for (int k = 0; k < 3; k++) if (m_pend[k] != 0 && m_mask[k]) irq_n = m_ctrl;
      m_rv = rd;
      m_rd = rd ? model_read(a) : 0;
      w1c = wr && (a == 0);
      for (int k = 0; k < 3; k++) begin
        np[k] = p[k] ? 1 : ((w1c && wd[k]) ? 0 : m_pend[k]);
        no[k] = (w1c && wd[k+3]) ? 0 : m_ovr[k];
        if (p[k] && m_pend[k] != 0 && !(w1c && wd[k])) no[k] = 1;
        if (wr && a == 3 + k) m_cnt[k] = p[k];
        else if (p[k] && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
      end
      for (int k = 0; k < 3; k++) begin m_pend[k] = np[k]; m_ovr[k] = no[k]; end
      if (wr && a == 1) m_mask = wd[2:0];
      if (wr && a == 2) m_ctrl = wd[0];
      m_irq = irq_n;
    end
    #1;
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd);
    chk("interrupt", interrupt, m_irq);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_pend[k] = 0; m_ovr[k] = 0; m_cnt[k] = 0; end
    m_mask = 0; m_ctrl = 0; m_irq = 0; m_rv = 0; m_rd = 0;
    cyc(3'b000, 1'b1, 1'b1, 1, 7, 1'b1, 1'b0);
    cyc(3'b000, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_irq", interrupt, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    chk("reset_mask", rd_data, 0);

    // enabled, unmasked single pulse
    cyc(0, 1, 0, 1, 7);
    cyc(0, 1, 0, 2, 1);
    repeat (3) cyc(0);
    cyc(3'b001);
    chk("req27_irq_n1", interrupt, 0);
    cyc(0, 0, 1, 0);
    chk("req27_status", rd_data, 32'h01);
    chk("req27_irq_n2", interrupt, 1);
    cyc(0, 1, 0, 0, 32'h01);
    cyc(0);

    // double pcfg pulse -> overrun, then W1C both
    cyc(3'b100); cyc(0); cyc(3'b100);
    cyc(0, 0, 1, 0);
    chk("req28_status", rd_data, 32'h24);
    cyc(0, 1, 0, 0, 32'h24);
    chk("req28_irq_w", interrupt, 1);
    cyc(0, 0, 1, 0);
    chk("req28_cleared", rd_data, 32'h00);
    chk("req28_irq_low", interrupt, 0);

    // set beats clear
    cyc(3'b010); cyc(0);
    cyc(3'b010, 1, 0, 0, 32'h02);
    cyc(0, 0, 1, 0);
    chk("req29_status", rd_data, 32'h02);
    chk("req29_irq", interrupt, 1);
    cyc(0, 1, 0, 0, 32'h3f); cyc(0);

    // mask and global enable gating
    cyc(0, 1, 0, 1, 1);
    cyc(3'b010); cyc(0);
    cyc(0, 0, 1, 0);
    chk("req30_status", rd_data, 32'h02);
    chk("req30_masked", interrupt, 0);
    cyc(0, 1, 0, 1, 7);
    cyc(0, 1, 0, 2, 0);
    cyc(0); cyc(0);
    chk("req30_ctrl0", interrupt, 0);
    cyc(0, 1, 0, 2, 1);
    cyc(0); cyc(0);
    chk("req30_ctrl1", interrupt, 1);
    cyc(0, 1, 0, 0, 32'h3f); cyc(0);

    // counters: saturation, clear, clear+pulse
    repeat (5) cyc(3'b001);
    cyc(0, 0, 1, 3);
    chk("req31_sat", rd_data, CNT_ON ? 32'd3 : 32'd0);
    cyc(0, 1, 0, 3, 32'hdead);
    cyc(0, 0, 1, 3);
    chk("req31_clr", rd_data, 0);
    cyc(3'b001, 1, 0, 3, 0);
    cyc(0, 0, 1, 3);
    chk("cnt_clr_pulse", rd_data, CNT_ON ? 32'd1 : 32'd0);
    cyc(0, 1, 0, 0, 32'h3f);

    // clk_en low drops everything and holds outputs
    cyc(0, 0, 1, 1);
    cyc(3'b111, 1, 1, 1, 0, 1'b0);
    chk("hold_valid", rd_valid, 1);
    chk("hold_data", rd_data, 7);
    cyc(0, 0, 1, 0);
    chk("hold_status", rd_data, 0);

    // simultaneous write and read returns pre-write value
    cyc(0, 1, 1, 1, 5);
    chk("wr_rd_old", rd_data, 7);
    cyc(0, 0, 1, 1);
    chk("wr_rd_new", rd_data, 5);
    cyc(0, 0, 1, 9);
    chk("unmapped", rd_data, 0);

    for (int i = 0; i < 400; i++)
      cyc(3'($urandom), ($urandom % 3) == 0, 1'($urandom), int'($urandom % 8), $urandom,
          ($urandom % 8) != 0, ($urandom % 100) != 0);

    // reset during a read with pending state
    cyc(0, 1, 0, 1, 7); cyc(0, 1, 0, 2, 1);
    cyc(3'b111); cyc(3'b111); cyc(0);
    cyc(0, 0, 1, 0, 0, 1'b1, 1'b0);
    chk("req32_valid", rd_valid, 0);
    chk("req32_irq", interrupt, 0);
    for (int a = 0; a < 6; a++) begin
      cyc(0, 0, 1, a);
      chk("req32_regs", rd_data, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/glb_tile_intr_ctrl.md
GLB_TILE_INTR_CTRL -- requirements
Module: glb_tile_intr_ctrl

Interface
REQ-001 SHALL have parameter CFG_ADDR_WIDTH, default 4, word address width of the register port.
REQ-002 SHALL have parameter CFG_DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16 (range 1..CFG_DATA_WIDTH), event counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port clk_en  input  1  state advances only when high.
REQ-007 SHALL have ports strm_f2g_interrupt_pulse, strm_g2f_interrupt_pulse, pcfg_g2f_interrupt_pulse  input  1 each  single-cycle done pulses from glb_core; these are source bits 0, 1, 2 respectively.
REQ-008 SHALL have port cfg_wr_en  input  1  register write strobe.
REQ-009 SHALL have port cfg_rd_en  input  1  register read strobe.
REQ-010 SHALL have port cfg_addr  input  CFG_ADDR_WIDTH  register word address.
REQ-011 SHALL have port cfg_wr_data  input  CFG_DATA_WIDTH  write data.
REQ-012 SHALL have port cfg_rd_data  output  CFG_DATA_WIDTH  read data.
REQ-013 SHALL have port cfg_rd_data_valid  output  1  read data qualifier.
REQ-014 SHALL have port interrupt  output  1  level interrupt to the processor.

Function
REQ-015 Register map (word addresses): 0 STATUS ([2:0] pending, [5:3] overrun, both write-1-to-clear), 1 MASK ([2:0], read/write), 2 CTRL ([0] global enable, read/write), 3..5 COUNT0..COUNT2 (conditional, REQ-026).
REQ-016 On clk_en high, a high source pulse bit k SHALL set pending[k] on the next edge.
REQ-017 A source pulse arriving while pending[k] is already 1 SHALL set overrun[k]; pending[k] stays 1.
REQ-018 Simultaneous source pulse and W1C of pending[k] in the same cycle: set wins, pending[k] = 1, overrun[k] unchanged by that pulse.
REQ-019 W1C of overrun[k] with a simultaneous overrun event: set wins.
REQ-020 interrupt SHALL be registered: interrupt = CTRL[0] & |(pending & MASK), one cycle after the state that produced it; a pulse at cycle N drives interrupt high at cycle N+2 when enabled and unmasked.
REQ-021 Reads SHALL have one-cycle latency: cfg_rd_en at cycle N gives cfg_rd_data and cfg_rd_data_valid=1 at N+1; cfg_rd_data_valid is 0 otherwise and cfg_rd_data is 0 when not valid.
REQ-022 Read data SHALL reflect register state before any same-cycle write or event update; unmapped addresses read 0; unused bits read 0; writes to unmapped addresses are ignored.
REQ-023 Simultaneous cfg_wr_en and cfg_rd_en SHALL both be honoured.
REQ-024 When clk_en is low, all registers and outputs SHALL hold; source pulses and cfg strobes in that cycle are dropped.

Reset
REQ-025 On reset low at a rising edge (regardless of clk_en): pending, overrun, MASK, CTRL, counters, interrupt, cfg_rd_data, cfg_rd_data_valid SHALL all be 0; a reset asserted mid-read discards that read.

Configuration
REQ-026 Macro GLB_INTR_COUNT_EN: when defined, COUNT0..2 are CNT_WIDTH saturating counters of source pulses per bit, incrementing by 1 per accepted pulse, holding at all-ones; a write of any value to COUNTk clears it, and a same-cycle pulse then leaves it at 1; when not defined, no counter logic exists and addresses 3..5 read 0 and ignore writes.

Verification
REQ-027 MASK=0x7, CTRL=1, strm_f2g pulse at cycle 10 -> STATUS reads 0x01, interrupt high at cycle 12.
REQ-028 Two pcfg_g2f pulses without clear -> STATUS=0x24; write STATUS=0x24 -> STATUS=0x00, interrupt low two cycles after the write.
REQ-029 W1C of 0x02 in the same cycle as a strm_g2f pulse -> STATUS reads 0x02, interrupt stays high.
REQ-030 MASK=0x1, g2f pulse -> STATUS=0x02, interrupt stays 0; CTRL=0 with an unmasked pending bit -> interrupt 0.
REQ-031 GLB_INTR_COUNT_EN, CNT_WIDTH=2, five f2g pulses -> COUNT0 reads 3; write COUNT0 -> reads 0; without the macro, COUNT0 reads 0.
REQ-032 Pending bits set, reset low for one cycle mid-read -> all registers 0, cfg_rd_data_valid 0, interrupt 0.
